// File: rtl/instruction_memory_sync.sv
// Synchronous program memory for the soft processor.
// Registered one-cycle fetch with stall, a word-wide run-time loader port,
// and a power-on clear sequence that fills every location with DEFAULT_WORD.
module instruction_memory_sync #(
    parameter int                    DATA_WIDTH   = 28,
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DEPTH        = 256,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = 28'h00000AA
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iFetchEn,
    input  logic [ADDR_WIDTH-1:0] iAddress,
    output logic [DATA_WIDTH-1:0] oInstruction,
    output logic                  oValid,
    input  logic                  iLoadEn,
    input  logic                  iLoadValid,
    input  logic [DATA_WIDTH-1:0] iLoadData,
    output logic                  oLoadReady,
    output logic                  oLoadDone,
    output logic [ADDR_WIDTH-1:0] oLoadCount,
    output logic                  oBusy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]    LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [1:0]            state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  valid_q, valid_d;

    logic                  wr_en;
    logic [PTR_W-1:0]      wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  fetch_fire;
    logic                  in_range;

    // Next-state logic for the clear/idle/load sequencer and the single write port
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = ptr_q;
        wr_data = DEFAULT_WORD;
        case (state_q)
            ST_CLEAR: begin
                wr_en = 1'b1;
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end
            end
            ST_IDLE: begin
                if (iLoadEn) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                // Dropping iLoadEn ends the session; a word offered in that cycle is dropped
                if (!iLoadEn) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (iLoadValid) begin
                    wr_en   = 1'b1;
                    wr_data = iLoadData;
                    ptr_d   = ptr_q + 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (ptr_q == LAST_PTR) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        ptr_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // Fetch path: only in idle, and a simultaneous load request takes priority
    always_comb begin
        fetch_fire = (state_q == ST_IDLE) && iFetchEn && !iLoadEn;
        in_range   = ({1'b0, iAddress} < DEPTH_EXT);
        valid_d    = fetch_fire;
        instr_d    = instr_q;
        if (fetch_fire) begin
            instr_d = in_range ? mem[iAddress[PTR_W-1:0]] : DEFAULT_WORD;
        end
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            instr_q <= DEFAULT_WORD;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    // Memory array write port; reset aborts any clear/load write in flight
    always_ff @(posedge Clock) begin
        if (wr_en && !Reset) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign oInstruction = instr_q;
    assign oValid       = valid_q;
    assign oLoadReady   = (state_q == ST_LOAD);
    assign oLoadDone    = done_q;
    assign oLoadCount   = cnt_q;
    assign oBusy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_instruction_memory_sync.sv
// Self-checking bench for instruction_memory_sync: reference memory model,
// fetch scoreboard drained by a monitor, and directed load/fetch scenarios.
module tb_instruction_memory_sync;

    localparam int DW = 28;
    localparam int AW = 16;
    localparam int DEPTH = 256;
    localparam logic [DW-1:0] DEF = 28'h00000AA;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          iFetchEn = 1'b0;
    logic [AW-1:0] iAddress = '0;
    logic [DW-1:0] oInstruction;
    logic          oValid;
    logic          iLoadEn = 1'b0;
    logic          iLoadValid = 1'b0;
    logic [DW-1:0] iLoadData = '0;
    logic          oLoadReady;
    logic          oLoadDone;
    logic [AW-1:0] oLoadCount;
    logic          oBusy;

    int n_checks = 0;
    int n_fail = 0;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] sb_q [$];

    instruction_memory_sync #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .DEPTH       (DEPTH),
        .DEFAULT_WORD(DEF)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .iFetchEn    (iFetchEn),
        .iAddress    (iAddress),
        .oInstruction(oInstruction),
        .oValid      (oValid),
        .iLoadEn     (iLoadEn),
        .iLoadValid  (iLoadValid),
        .iLoadData   (iLoadData),
        .oLoadReady  (oLoadReady),
        .oLoadDone   (oLoadDone),
        .oLoadCount  (oLoadCount),
        .oBusy       (oBusy)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Every valid output must match the oldest outstanding fetch
    always @(negedge Clock) begin
        if (oValid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 32'(oInstruction), 32'hFFFF_FFFF);
            end else begin
                check("fetch_data", 32'(oInstruction), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [DW-1:0] exp_word(input int a);
        return (a < DEPTH) ? model[a] : DEF;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = DEF;
    endtask

    // Leaves iFetchEn high so calls can be chained back-to-back
    task automatic fetch(input int a);
        iFetchEn = 1'b1;
        iAddress = AW'(a);
        sb_q.push_back(exp_word(a));
        tick();
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (oBusy && n < 1000);
        check(tag, 32'(n), 32'(DEPTH));
    endtask

    // Load session: slot i carries base+i, valid when vmask[i]; then iLoadEn drops
    task automatic do_load(input string tag, input int slots, input logic [31:0] vmask,
                           input logic [DW-1:0] base, input logic fetch_too);
        int wp;
        wp = 0;
        iLoadEn  = 1'b1;
        iFetchEn = fetch_too;
        iAddress = AW'(1);
        tick();
        check({tag, "_ready"}, 32'(oLoadReady), 32'd1);
        check({tag, "_busy"}, 32'(oBusy), 32'd1);
        for (int i = 0; i < slots; i++) begin
            iLoadValid = vmask[i];
            iLoadData  = base + DW'(i);
            if (vmask[i]) begin
                model[wp] = base + DW'(i);
                wp++;
            end
            tick();
        end
        iFetchEn   = 1'b0;
        iLoadEn    = 1'b0;
        iLoadValid = 1'b1;
        iLoadData  = 28'hBADBEEF;
        tick();
        iLoadValid = 1'b0;
        check({tag, "_done"}, 32'(oLoadDone), 32'd1);
        check({tag, "_count"}, 32'(oLoadCount), 32'(wp));
        tick();
        check({tag, "_done_pulse"}, 32'(oLoadDone), 32'd0);
        check({tag, "_idle"}, 32'(oBusy), 32'd0);
        check({tag, "_count_hold"}, 32'(oLoadCount), 32'(wp));
    endtask

    initial begin
        model_clear();

        // 1: reset values, clear duration, first fetch
        Reset = 1'b1;
        tick();
        check("rst_busy", 32'(oBusy), 32'd1);
        check("rst_valid", 32'(oValid), 32'd0);
        check("rst_ready", 32'(oLoadReady), 32'd0);
        check("rst_done", 32'(oLoadDone), 32'd0);
        check("rst_count", 32'(oLoadCount), 32'd0);
        check("rst_instr", 32'(oInstruction), 32'(DEF));
        Reset = 1'b0;
        wait_idle("clear_cycles");
        fetch(5);
        iFetchEn = 1'b0;
        check("t1_valid", 32'(oValid), 32'd1);

        // 2: load four words (fetch requested concurrently and ignored), read back
        do_load("t2", 4, 32'hF, 28'h1000001, 1'b1);
        fetch(0); fetch(1); fetch(2); fetch(3);
        iFetchEn = 1'b0;
        tick();
        check("t2_valid_off", 32'(oValid), 32'd0);

        // 3: out-of-range fetch, then a stall holds the last word
        fetch(300);
        fetch(2);
        iFetchEn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_stall_valid", 32'(oValid), 32'd0);
            check("t3_stall_hold", 32'(oInstruction), 32'(model[2]));
        end

        // 4: gapped load, only valid cycles write
        do_load("t4", 5, 32'b10101, 28'h2000000, 1'b0);
        fetch(0); fetch(1); fetch(2); fetch(3);
        iFetchEn = 1'b0;
        tick();

        // 5: full-depth stream with automatic exit
        iLoadEn = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            iLoadValid = 1'b1;
            iLoadData  = 28'h3000000 + DW'(i);
            model[i]   = 28'h3000000 + DW'(i);
            tick();
            if (i == DEPTH - 2) begin
                check("t5_no_early_done", 32'(oLoadDone), 32'd0);
                check("t5_ready_mid", 32'(oLoadReady), 32'd1);
            end
        end
        check("t5_done", 32'(oLoadDone), 32'd1);
        check("t5_count", 32'(oLoadCount), 32'd256);
        check("t5_ready_off", 32'(oLoadReady), 32'd0);
        check("t5_idle", 32'(oBusy), 32'd0);
        iLoadEn   = 1'b0;
        iLoadData = 28'h0DEAD00;
        tick();
        iLoadValid = 1'b0;
        check("t5_done_pulse", 32'(oLoadDone), 32'd0);
        check("t5_count_hold", 32'(oLoadCount), 32'd256);
        fetch(0); fetch(128); fetch(255); fetch(256);
        iFetchEn = 1'b0;
        tick();

        // 6: reset in the middle of a load
        iLoadEn = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            iLoadValid = 1'b1;
            iLoadData  = 28'h4000000 + DW'(i);
            tick();
        end
        iLoadData = 28'h4000002;
        Reset = 1'b1;
        tick();
        check("t6_no_done", 32'(oLoadDone), 32'd0);
        check("t6_busy", 32'(oBusy), 32'd1);
        check("t6_ready_off", 32'(oLoadReady), 32'd0);
        check("t6_count_rst", 32'(oLoadCount), 32'd0);
        Reset      = 1'b0;
        iLoadEn    = 1'b0;
        iLoadValid = 1'b0;
        model_clear();
        wait_idle("t6_clear_cycles");
        check("t6_done_quiet", 32'(oLoadDone), 32'd0);
        fetch(0); fetch(1); fetch(255);
        iFetchEn = 1'b0;
        tick();
        tick();

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
